// File: rtl/moore_step_pkg.sv
// Shared encodings for the Moore step counter: step modes and
// active-low seven-segment glyphs ({g,f,e,d,c,b,a}).
package moore_step_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_SAT  = 2'b10,
    MODE_HOLD = 2'b11
  } step_mode_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex glyphs 0..F in index order.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/step_tick_gen.sv
// Clock-enable divider: emits a registered one-cycle tick every TICK_DIV
// clocks so the counter never needs a derived clock.
module step_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/moore_step_counter.sv
// Modulo-NUM_STATES step counter advanced by a divided tick, with run-time
// mode, synchronous clamped load, wrap pulse and a seven-segment decode.
module moore_step_counter
  import moore_step_pkg::*;
#(
  parameter  int NUM_STATES = 6,
  parameter  int TICK_DIV   = 25000000,
  localparam int W          = $clog2(NUM_STATES)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   mode,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state,
  output logic [6:0]   seg,
  output logic         tick,
  output logic         wrap
);

  localparam logic [W:0] LAST = (W + 1)'(NUM_STATES - 1);

  logic [W:0] state_x;
  logic [3:0] digit;

  // One extra bit keeps +1 from overflowing when NUM_STATES is a power of two.
  assign state_x = {1'b0, state};
  assign digit   = 4'(state);

  step_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      state <= ({1'b0, load_val} > LAST) ? W'(LAST) : load_val;
      wrap  <= 1'b0;
    end else if (tick) begin
      wrap <= 1'b0;
      case (step_mode_e'(mode))
        MODE_UP: begin
          if (state_x == LAST) begin
            state <= '0;
            wrap  <= 1'b1;
          end else begin
            state <= W'(state_x + (W + 1)'(1));
          end
        end
        MODE_DOWN: begin
          if (state_x == '0) begin
            state <= W'(LAST);
            wrap  <= 1'b1;
          end else begin
            state <= W'(state_x - (W + 1)'(1));
          end
        end
        MODE_SAT: begin
          if (state_x < LAST) state <= W'(state_x + (W + 1)'(1));
        end
        MODE_HOLD: state <= state;
      endcase
    end else begin
      wrap <= 1'b0;
    end
  end

  // NOTE: the default assignment first guarantees seg is driven on every
  // path, so no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (state_x <= LAST) seg = SEG_PATTERNS[digit];
  end

endmodule

// File: tb/tb_moore_step_counter.sv
// Scoreboard bench: two counters (6 states / div 4 and 16 states / div 1)
// driven by directed and random stimulus, checked against a behavioural model.
module tb_moore_step_counter;

  logic       clock;
  logic       rst_a, load_a, tick_a, wrap_a;
  logic [1:0] mode_a;
  logic [2:0] lv_a, state_a;
  logic [6:0] seg_a;
  logic       rst_b, load_b, tick_b, wrap_b;
  logic [1:0] mode_b;
  logic [3:0] lv_b, state_b;
  logic [6:0] seg_b;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int st;
    int n;      // edges since reset release
    bit tick;
    bit wrap;
  } model_t;

  typedef struct {
    int         st;
    logic [6:0] seg;
    bit         tick;
    bit         wrap;
  } exp_t;

  model_t ma, mb;
  exp_t   qa[$];
  exp_t   qb[$];

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  moore_step_counter #(.NUM_STATES(6), .TICK_DIV(4)) dut_a (
    .clock    (clock),
    .reset    (rst_a),
    .mode     (mode_a),
    .load     (load_a),
    .load_val (lv_a),
    .state    (state_a),
    .seg      (seg_a),
    .tick     (tick_a),
    .wrap     (wrap_a)
  );

  moore_step_counter #(.NUM_STATES(16), .TICK_DIV(1)) dut_b (
    .clock    (clock),
    .reset    (rst_b),
    .mode     (mode_b),
    .load     (load_b),
    .load_val (lv_b),
    .state    (state_b),
    .seg      (seg_b),
    .tick     (tick_b),
    .wrap     (wrap_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: tick every td-th edge after release, steps use the
  // tick that was visible before the edge, load wins over stepping.
  function automatic model_t model_step(model_t m, int ns, int td, bit rst,
                                        int mode, bit load, int lv);
    model_t r = m;
    if (!rst) begin
      r.st = 0; r.n = 0; r.tick = 0; r.wrap = 0;
      return r;
    end
    r.n    = m.n + 1;
    r.tick = (r.n % td) == 0;
    r.wrap = 0;
    if (load) begin
      r.st = (lv > ns - 1) ? ns - 1 : lv;
    end else if (m.tick) begin
      case (mode)
        0: begin r.st = (m.st + 1) % ns;      r.wrap = (m.st == ns - 1); end
        1: begin r.st = (m.st + ns - 1) % ns; r.wrap = (m.st == 0);      end
        2: r.st = (m.st + 1 > ns - 1) ? ns - 1 : m.st + 1;
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic exp_t to_exp(model_t m);
    exp_t e;
    e.st   = m.st;
    e.seg  = seg_ref[m.st];
    e.tick = m.tick;
    e.wrap = m.wrap;
    return e;
  endfunction

  // Predict the coming edge from the present inputs, then let it happen.
  task automatic step_cycle();
    ma = model_step(ma, 6, 4, rst_a, int'(mode_a), load_a, int'(lv_a));
    mb = model_step(mb, 16, 1, rst_b, int'(mode_b), load_b, int'(lv_b));
    qa.push_back(to_exp(ma));
    qb.push_back(to_exp(mb));
    @(negedge clock);
  endtask

  // Monitor: every edge both counters present a result; compare in order.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      check("sb_a {state,seg,tick,wrap}", {state_a, seg_a, tick_a, wrap_a},
            {3'(e.st), e.seg, e.tick, e.wrap});
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      check("sb_b {state,seg,tick,wrap}", {state_b, seg_b, tick_b, wrap_b},
            {4'(e.st), e.seg, e.tick, e.wrap});
    end
  end

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    rst_a = 1'b0; mode_a = 2'b00; load_a = 1'b1; lv_a = 3'd3;
    rst_b = 1'b0; mode_b = 2'b00; load_b = 1'b0; lv_b = 4'd0;

    // Reset overrides a pending load.
    repeat (3) step_cycle();
    check("reset_state", state_a, 0);
    check("reset_seg", seg_a, 7'b1000000);

    // Up-wrap through 5 -> 0.
    rst_a = 1'b1; load_a = 1'b0; mode_a = 2'b00;
    repeat (28) step_cycle();

    // Down-wrap from 0.
    mode_a = 2'b01;
    repeat (12) step_cycle();

    // Saturate, then hold.
    load_a = 1'b1; lv_a = 3'd4; mode_a = 2'b10;
    step_cycle();
    load_a = 1'b0;
    repeat (20) step_cycle();
    check("sat_state", state_a, 5);
    mode_a = 2'b11;
    repeat (12) step_cycle();
    check("hold_state", state_a, 5);

    // Load colliding with a visible tick from state 4 in up mode.
    load_a = 1'b1; lv_a = 3'd4;
    step_cycle();
    load_a = 1'b0;
    for (int i = 0; i < 8 && !ma.tick; i++) step_cycle();
    check("collide_tick_seen", tick_a, 1);
    mode_a = 2'b00; load_a = 1'b1; lv_a = 3'd2;
    step_cycle();
    check("collide_load_wins", state_a, 2);
    lv_a = 3'd7;
    step_cycle();
    check("load_clamp", state_a, 5);
    load_a = 1'b0;
    repeat (10) step_cycle();

    // Wide counter with tick every cycle: mid-run reset, then 15 -> 0.
    mode_a = 2'b11;
    rst_b = 1'b1; mode_b = 2'b00;
    for (int i = 0; i < 40 && mb.st != 9; i++) step_cycle();
    check("b_reach_9", state_b, 9);
    rst_b = 1'b0;
    step_cycle();
    check("b_midrun_reset", {state_b, wrap_b}, 0);
    rst_b = 1'b1;
    for (int i = 0; i < 40 && mb.st != 15; i++) step_cycle();
    check("b_seg_15", seg_b, 7'b0001110);
    step_cycle();
    check("b_wrap_15_0", {state_b, wrap_b}, {4'd0, 1'b1});

    // Random traffic on both counters.
    for (int i = 0; i < 600; i++) begin
      rst_a  = ($urandom_range(0, 49) != 0);
      mode_a = 2'($urandom);
      load_a = ($urandom_range(0, 7) == 0);
      lv_a   = 3'($urandom);
      rst_b  = ($urandom_range(0, 49) != 0);
      mode_b = 2'($urandom);
      load_b = ($urandom_range(0, 7) == 0);
      lv_b   = 4'($urandom);
      step_cycle();
    end

    @(posedge clock);
    #2;
    check("sb_drained", qa.size() + qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
